// File: rtl/adapter_1_to_4_pkg.sv
// Shared types and defaults for the 1-to-N lane unpacker.
// Imported by the interface and the top module.
package adapter_1_to_4_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_N_INPUTS   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/adapter_1_to_4_if.sv
// Wide-in / narrow-out stream bundle for the lane unpacker.
// slave is the unpacker's view, master is the surrounding fabric.
interface adapter_1_to_4_if
    import adapter_1_to_4_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_INPUTS   = DEF_N_INPUTS
) ();

    localparam int LANE_W = clog2(N_INPUTS);

    logic                           in_valid;
    logic                           in_ready;
    logic [N_INPUTS*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [LANE_W-1:0]              out_lane;
    logic                           out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_lane,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_lane,
        input  out_last
    );

endinterface

// File: rtl/adapter_1_to_4.sv
// Unpacks one wide word into N_INPUTS narrow beats, lane 0 first.
// Reloads on the last beat so consecutive words stream without a bubble.
module adapter_1_to_4
    import adapter_1_to_4_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int N_INPUTS   = DEF_N_INPUTS
) (
    input  logic              clk,
    input  logic              reset,
    adapter_1_to_4_if.slave   bus
);

    localparam int LANE_W = clog2(N_INPUTS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_INPUTS - 1);

    state_t                         state_q;
    state_t                         state_d;
    logic [N_INPUTS*DATA_WIDTH-1:0] word_q;
    logic [LANE_W-1:0]              cnt_q;
    logic [LANE_W-1:0]              cnt_d;
    logic                           load;
    logic                           at_last;
    logic                           in_ready;
    logic                           out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                word_q <= bus.in_data;
            end
        end
    end

    assign at_last = (state_q == ST_SEND) && (cnt_q == LAST_LANE);

    // out_ready -> in_ready is the only combinational through-path
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                in_ready  = at_last && bus.out_ready;
                if (bus.out_ready) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (bus.in_valid) begin
                        load  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = word_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
    assign bus.out_lane  = cnt_q;
    assign bus.out_last  = at_last;

endmodule

// File: tb/tb_adapter_1_to_4.sv
// Randomised and directed bench for the lane unpacker.
// A queue of pending lanes predicts every output each cycle.
module tb_adapter_1_to_4;
    import adapter_1_to_4_pkg::*;

    localparam int DW = 16;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adapter_1_to_4_if #(.DATA_WIDTH(DW), .N_INPUTS(N)) bus ();

    adapter_1_to_4 #(.DATA_WIDTH(DW), .N_INPUTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0]   mq_d[$];
    int              mq_l[$];
    logic [N*DW-1:0] send_q[$];
    bit              rdy_seq[$];
    logic [DW-1:0]   log_d[$];
    bit              log_rdy[$];
    bit              log_v[$];
    bit              hold = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_logs();
        log_d.delete();
        log_rdy.delete();
        log_v.delete();
    endtask

    // One clock: drive at negedge, compare at negedge+1, update model at posedge
    task automatic cycle(input int vp, input int rp);
        bit ev;
        bit er;
        bit acc;
        logic [N*DW-1:0] w;
        @(negedge clk);
        bus.in_valid = (send_q.size() > 0) &&
                       (hold || ($urandom_range(99) < vp));
        w = {$urandom, $urandom};
        bus.in_data = bus.in_valid ? send_q[0] : w;
        if (rdy_seq.size() > 0) bus.out_ready = rdy_seq.pop_front();
        else bus.out_ready = ($urandom_range(99) < rp);
        #1;
        ev = (mq_d.size() > 0);
        er = !ev || ((mq_d.size() == 1) && bus.out_ready);
        chk("out_valid", bus.out_valid, ev);
        if (ev) begin
            chk("out_data", bus.out_data, mq_d[0]);
            chk("out_lane", bus.out_lane, mq_l[0]);
            chk("out_last", bus.out_last, mq_l[0] == N - 1);
        end
        chk("in_ready", bus.in_ready, er);
        log_v.push_back(bus.out_valid);
        if (ev && bus.out_ready) begin
            log_d.push_back(bus.out_data);
            log_rdy.push_back(bus.in_ready);
        end
        acc = bus.in_valid && er;
        @(posedge clk);
        if (ev && bus.out_ready) begin
            void'(mq_d.pop_front());
            void'(mq_l.pop_front());
        end
        if (acc) begin
            w = send_q.pop_front();
            for (int k = 0; k < N; k++) begin
                mq_d.push_back(w[k*DW +: DW]);
                mq_l.push_back(k);
            end
        end
        hold = bus.in_valid && !acc;
    endtask

    task automatic drain(input int vp, input int rp, input int budget);
        int guard;
        guard = 0;
        while ((mq_d.size() > 0 || send_q.size() > 0) && guard < budget) begin
            cycle(vp, rp);
            guard++;
        end
        if (guard >= budget) chk("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_lane", bus.out_lane, 0);
        mq_d.delete();
        mq_l.delete();
        send_q.delete();
        rdy_seq.delete();
        hold = 1'b0;
        @(posedge clk);
        #1 chk("rst_hold_valid", bus.out_valid, 0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    int nv;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("init_out_valid", bus.out_valid, 0);
        chk("init_in_ready", bus.in_ready, 1);
        chk("init_out_data", bus.out_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single word, out_ready held high
        clear_logs();
        send_q.push_back(64'hCDEF_89AB_4567_0123);
        repeat (6) cycle(100, 100);
        chk("single_n", log_d.size(), 4);
        chk("single_l0", log_d[0], 16'h0123);
        chk("single_l1", log_d[1], 16'h4567);
        chk("single_l2", log_d[2], 16'h89AB);
        chk("single_l3", log_d[3], 16'hCDEF);
        chk("single_lat", log_v[1], 1);
        chk("single_idle", log_v[5], 0);

        // back-to-back words stream without a gap
        clear_logs();
        send_q.push_back(64'hCDEF_89AB_4567_0123);
        send_q.push_back(64'h0123_4567_89AB_CDEF);
        repeat (10) cycle(100, 100);
        nv = 0;
        for (int i = 1; i <= 8; i++) nv += int'(log_v[i]);
        chk("b2b_beats", nv, 8);
        chk("b2b_idle", log_v[9], 0);
        chk("b2b_rdy", {log_rdy[0], log_rdy[1], log_rdy[2], log_rdy[3]},
            4'b0001);
        chk("b2b_w1l0", log_d[4], 16'hCDEF);
        chk("b2b_w1l3", log_d[7], 16'h0123);

        // backpressure on lane 1
        clear_logs();
        send_q.push_back(64'h0123_00BB_0AAA_AAAA);
        rdy_seq = '{1, 1, 0, 0, 0, 1, 1, 1};
        repeat (8) cycle(100, 100);
        chk("bp_n", log_d.size(), 4);
        chk("bp_l0", log_d[0], 16'hAAAA);
        chk("bp_l1", log_d[1], 16'h0AAA);
        chk("bp_l2", log_d[2], 16'h00BB);
        chk("bp_l3", log_d[3], 16'h0123);

        // abort mid-word
        send_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        rdy_seq = '{1, 1, 1};
        repeat (3) cycle(100, 100);
        do_reset();
        clear_logs();
        send_q.push_back(64'h1111_2222_3333_4444);
        repeat (6) cycle(100, 100);
        chk("abort_first", log_d[0], 16'h4444);
        chk("abort_n", log_d.size(), 4);
        chk("abort_last", log_d[3], 16'h1111);
        chk("abort_nostale", log_v[0], 0);

        // random words, random valid and ready
        clear_logs();
        for (int i = 0; i < 40; i++) send_q.push_back({$urandom, $urandom});
        drain(60, 70, 3000);
        chk("rand_lanes", log_d.size(), 4 * 40);

        // reset while streaming, then more random traffic
        for (int i = 0; i < 5; i++) send_q.push_back({$urandom, $urandom});
        repeat (7) cycle(100, 80);
        do_reset();
        for (int i = 0; i < 20; i++) send_q.push_back({$urandom, $urandom});
        drain(80, 50, 3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
